// File: rtl/erasure_position_gen.sv
// erasure_position_gen: collects erasure roots alpha^(n-1-k) for the erased symbols of a
// 255-symbol RS codeword and serves them one per request cycle to the erasure locator.
// Optional build macro ERASURE_PINGPONG_EN adds a second root bank so the next block can be
// collected while the current one is being served.
module erasure_position_gen #(
    parameter int unsigned width        = 5,
    parameter int unsigned max_erasures = 16,
    parameter int unsigned block_length = 255,
    parameter logic [7:0]  start_power  = 8'h8E
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_erase,
    input  logic             in_last,
    input  logic [width-1:0] no_of_parity,
    input  logic             send_erasure_positions_for_loc,
    output logic [7:0]       erase_position,
    output logic             erasure_ready,
    output logic             erase_pos_done,
    output logic [width-1:0] number_of_erasures,
    output logic             erasure_overflow
);

`ifdef ERASURE_PINGPONG_EN
    localparam int unsigned NumBanks = 2;
`else
    localparam int unsigned NumBanks = 1;
`endif
    localparam int unsigned IdxW = (max_erasures > 1) ? $clog2(max_erasures) : 1;
    localparam int unsigned SymW = $clog2(block_length);
    localparam logic [SymW-1:0]  LastSym = SymW'(block_length - 1);
    localparam logic [width-1:0] MaxErr  = width'(max_erasures);
    // Multiplying by alpha^-1 under 0x11D folds the low bit back in as 0x11D >> 1.
    localparam logic [7:0]       AlphaInvFold = 8'h8E;

    typedef enum logic [2:0] {StIdle, StCollect, StReady, StSend, StDone} state_e;

    state_e state_q, state_d;

    logic [7:0]                               power_q, power_d;
    logic [SymW-1:0]                          sym_q, sym_d;
    logic                                     col_open_q, col_open_d;
    logic [NumBanks-1:0][width-1:0]           cnt_q, cnt_d;
    logic [NumBanks-1:0]                      ovf_q, ovf_d;
    logic [NumBanks-1:0][max_erasures-1:0][7:0] mem_q, mem_d;
    logic [width-1:0]                         rd_q, rd_d;
    logic [width-1:0]                         num_q, num_d;
    logic [7:0]                               pos_q, pos_d;
    logic                                     rdy_q, rdy_d;
    logic                                     done_q, done_d;

    logic srv_bank;
    logic col_bank;

`ifdef ERASURE_PINGPONG_EN
    logic       srv_bank_q, srv_bank_d;
    logic [1:0] full_q, full_d;
    assign srv_bank = srv_bank_q;
    // The serving bank collects only for the first block; afterwards the other bank fills.
    assign col_bank = (state_q == StIdle || state_q == StCollect) ? srv_bank_q : ~srv_bank_q;
`else
    assign srv_bank = 1'b0;
    assign col_bank = 1'b0;
`endif

    logic             req;
    logic             accept;
    logic [7:0]       base_power;
    logic [SymW-1:0]  base_sym;
    logic [width-1:0] base_cnt;
    logic             base_ovf;
    logic [width-1:0] limit;
    logic             store;
    logic [width-1:0] new_cnt;
    logic             new_ovf;
    logic [7:0]       new_power;
    logic             blk_end;
    logic [width-1:0] srv_cnt;
    logic             emit;
    logic             finish;

    assign req     = send_erasure_positions_for_loc;
    assign srv_cnt = cnt_q[srv_bank];

    // Decide whether the symbol slot on the input is taken this cycle.
    always_comb begin
        accept = 1'b0;
        case (state_q)
            StIdle, StCollect: accept = in_valid;
`ifdef ERASURE_PINGPONG_EN
            StReady, StSend, StDone: accept = in_valid && !full_q[~srv_bank_q];
`else
            StDone: accept = in_valid;
`endif
            default: accept = 1'b0;
        endcase
    end

    // Per-symbol collection step; a closed collector starts the block from fresh values.
    always_comb begin
        base_power = col_open_q ? power_q : start_power;
        base_sym   = col_open_q ? sym_q : '0;
        base_cnt   = col_open_q ? cnt_q[col_bank] : '0;
        base_ovf   = col_open_q ? ovf_q[col_bank] : 1'b0;
        limit      = (no_of_parity < MaxErr) ? no_of_parity : MaxErr;
        store      = in_erase && (base_cnt < limit);
        new_cnt    = base_cnt + width'(store);
        new_ovf    = base_ovf | (in_erase && !(base_cnt < limit));
        new_power  = base_power[0] ? ((base_power >> 1) ^ AlphaInvFold) : (base_power >> 1);
        blk_end    = in_last || (base_sym == LastSym);
    end

    // Serving decisions: hand out one root per request, or flag completion.
    always_comb begin
        emit   = 1'b0;
        finish = 1'b0;
        case (state_q)
            StReady: begin
                emit   = req && (srv_cnt != '0);
                finish = req && (srv_cnt == '0);
            end
            StSend: begin
                finish = (rd_q == srv_cnt);
                emit   = req && (rd_q != srv_cnt);
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StCollect: if (accept && blk_end) state_d = StReady;
                               else if (accept)       state_d = StCollect;
            StReady: if (emit) state_d = StSend;
                     else if (finish) state_d = StDone;
            StSend:  if (finish) state_d = StDone;
            StDone: begin
`ifdef ERASURE_PINGPONG_EN
                if (full_q[~srv_bank_q]) state_d = StReady;
`else
                if (accept) state_d = blk_end ? StReady : StCollect;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        power_d    = power_q;
        sym_d      = sym_q;
        col_open_d = col_open_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        mem_d      = mem_q;
        rd_d       = rd_q;
        num_d      = num_q;
        pos_d      = pos_q;
        rdy_d      = 1'b0;
        done_d     = done_q;
`ifdef ERASURE_PINGPONG_EN
        srv_bank_d = srv_bank_q;
        full_d     = full_q;
`endif
        if (accept) begin
            power_d         = new_power;
            sym_d           = base_sym + SymW'(1);
            col_open_d      = !blk_end;
            cnt_d[col_bank] = new_cnt;
            ovf_d[col_bank] = new_ovf;
            if (store) mem_d[col_bank][base_cnt[IdxW-1:0]] = base_power;
            if (col_bank == srv_bank) begin
                done_d = 1'b0;
                rd_d   = '0;
                if (blk_end) num_d = new_cnt;
            end
`ifdef ERASURE_PINGPONG_EN
            else if (blk_end) begin
                full_d[col_bank] = 1'b1;
            end
`endif
        end
        if (emit) begin
            pos_d = mem_q[srv_bank][rd_q[IdxW-1:0]];
            rdy_d = 1'b1;
            rd_d  = rd_q + width'(1);
        end
        if (finish) done_d = 1'b1;
`ifdef ERASURE_PINGPONG_EN
        // Swap to the waiting bank once the current one has been fully delivered.
        if (state_q == StDone && full_q[~srv_bank_q]) begin
            srv_bank_d          = ~srv_bank_q;
            full_d[~srv_bank_q] = 1'b0;
            num_d               = cnt_q[~srv_bank_q];
            rd_d                = '0;
            done_d              = 1'b0;
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            power_q    <= start_power;
            sym_q      <= '0;
            col_open_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            mem_q      <= '0;
            rd_q       <= '0;
            num_q      <= '0;
            pos_q      <= '0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef ERASURE_PINGPONG_EN
            srv_bank_q <= 1'b0;
            full_q     <= '0;
`endif
        end else begin
            power_q    <= power_d;
            sym_q      <= sym_d;
            col_open_q <= col_open_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            num_q      <= num_d;
            pos_q      <= pos_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
`ifdef ERASURE_PINGPONG_EN
            srv_bank_q <= srv_bank_d;
            full_q     <= full_d;
`endif
        end
    end

    assign erase_position     = pos_q;
    assign erasure_ready      = rdy_q;
    assign erase_pos_done     = done_q;
    assign number_of_erasures = num_q;
    assign erasure_overflow   = ovf_q[srv_bank];

endmodule

// File: tb/tb_erasure_position_gen.sv
// Testbench for erasure_position_gen: randomized blocks checked against a GF(2^8) reference
// model; expected roots go into a scoreboard queue that a monitor drains on erasure_ready.
module tb_erasure_position_gen;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_erase;
    logic       in_last;
    logic [4:0] no_of_parity;
    logic       send;
    logic [7:0] erase_position;
    logic       erasure_ready;
    logic       erase_pos_done;
    logic [4:0] number_of_erasures;
    logic       erasure_overflow;

    erasure_position_gen dut (
        .clock                          (clock),
        .reset                          (reset),
        .in_valid                       (in_valid),
        .in_erase                       (in_erase),
        .in_last                        (in_last),
        .no_of_parity                   (no_of_parity),
        .send_erasure_positions_for_loc (send),
        .erase_position                 (erase_position),
        .erasure_ready                  (erasure_ready),
        .erase_pos_done                 (erase_pos_done),
        .number_of_erasures             (number_of_erasures),
        .erasure_overflow               (erasure_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    bit         pat[255];

    // Serve-side model state for the block being delivered.
    int m_n;
    int m_served;
    bit m_done;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // alpha^(254-k) by repeated multiplication by alpha modulo 0x11D.
    function automatic logic [7:0] gf_root(input int k);
        logic [7:0] v;
        v = 8'h01;
        for (int j = 0; j < 254 - k; j++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        return v;
    endfunction

    // Scoreboard monitor: every strobe must carry the next expected root.
    always @(negedge clock) begin
        if (!reset && erasure_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL root_strobe: got root %02h expected no strobe", erase_position);
            end else begin
                check("root", 32'(erase_position), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_pat();
        for (int i = 0; i < 255; i++) pat[i] = 1'b0;
    endtask

    // Stream one block; expected roots are queued only once the block is complete.
    task automatic drive_block(input int len, input bit use_last, input int parity,
                               input bit gaps, output int n, output bit ovf);
        int         lim;
        logic [7:0] roots[$];
        lim = (parity < 16) ? parity : 16;
        n   = 0;
        ovf = 1'b0;
        no_of_parity = 5'(parity);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_erase = 1'($urandom_range(0, 1));
                in_last  = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            in_valid = 1'b1;
            in_erase = pat[i];
            in_last  = use_last && (i == len - 1);
            @(negedge clock);
            if (pat[i]) begin
                if (n < lim) begin
                    roots.push_back(gf_root(i));
                    n++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_erase = 1'b0;
        in_last  = 1'b0;
        @(negedge clock);
        foreach (roots[i]) exp_q.push_back(roots[i]);
    endtask

    task automatic check_collected(input int n, input bit ovf);
        check("num_erasures", 32'(number_of_erasures), 32'(n));
        check("overflow", 32'(erasure_overflow), 32'(ovf));
        check("done_clear", 32'(erase_pos_done), 32'd0);
        m_n      = n;
        m_served = 0;
        m_done   = 1'b0;
    endtask

    // One request cycle: a stored root per request, done one edge after the last root
    // (or on the first request when nothing was stored).
    task automatic serve_step(input bit r);
        bit exp_rdy;
        send = r;
        @(negedge clock);
        exp_rdy = 1'b0;
        if (!m_done) begin
            if (m_served == m_n && (m_n != 0 || r)) m_done = 1'b1;
            else if (r) begin
                exp_rdy = 1'b1;
                m_served++;
            end
        end
        check("ready_strobe", 32'(erasure_ready), 32'(exp_rdy));
        check("done_level", 32'(erase_pos_done), 32'(m_done));
    endtask

    task automatic serve_until_done(input int pct);
        int guard;
        guard = 0;
        while (!m_done && guard < 400) begin
            serve_step($urandom_range(0, 99) < pct);
            guard++;
        end
        send = 1'b0;
        if (!m_done) begin
            vectors++;
            miscompares++;
            $display("FAIL serve_timeout: got no done after %0d cycles expected done", guard);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_block(input int len, input bit use_last, input int parity,
                             input bit gaps, input int pct);
        int n;
        bit ovf;
        drive_block(len, use_last, parity, gaps, n, ovf);
        check_collected(n, ovf);
        serve_until_done(pct);
    endtask

    task automatic check_reset_state();
        check("rst_position", 32'(erase_position), 32'd0);
        check("rst_ready", 32'(erasure_ready), 32'd0);
        check("rst_done", 32'(erase_pos_done), 32'd0);
        check("rst_num", 32'(number_of_erasures), 32'd0);
        check("rst_overflow", 32'(erasure_overflow), 32'd0);
    endtask

    initial begin
        int n;
        bit ovf;
        bit tog[5];
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_erase     = 1'b0;
        in_last      = 1'b0;
        no_of_parity = 5'd16;
        send         = 1'b0;
        m_n = 0; m_served = 0; m_done = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_state();
        reset = 1'b0;
        @(negedge clock);

        // Erasures at 0, 1 and 254, continuous request.
        clear_pat();
        pat[0] = 1'b1; pat[1] = 1'b1; pat[254] = 1'b1;
        run_block(255, 1'b1, 16, 1'b0, 100);

        // No erasures at all.
        clear_pat();
        run_block(100, 1'b1, 16, 1'b0, 100);

        // 18 erasures against a limit of 16.
        clear_pat();
        for (int i = 0; i < 18; i++) pat[i * 7] = 1'b1;
        run_block(200, 1'b1, 16, 1'b0, 100);

        // Request pattern 1,0,0,1,1 with three stored roots.
        clear_pat();
        pat[10] = 1'b1; pat[20] = 1'b1; pat[30] = 1'b1;
        drive_block(40, 1'b1, 16, 1'b0, n, ovf);
        check_collected(n, ovf);
        tog[0] = 1'b1; tog[1] = 1'b0; tog[2] = 1'b0; tog[3] = 1'b1; tog[4] = 1'b1;
        for (int i = 0; i < 5; i++) serve_step(tog[i]);
        serve_until_done(100);

        // Reset in the middle of collecting a block with 5 erasures.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_erase = (i % 2 == 0);
            in_last  = 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_erase = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check_reset_state();
        reset = 1'b0;
        @(negedge clock);
        clear_pat();
        pat[3] = 1'b1; pat[50] = 1'b1;
        run_block(60, 1'b1, 16, 1'b1, 100);

        // Block ended by the symbol counter, no in_last.
        clear_pat();
        pat[200] = 1'b1; pat[254] = 1'b1;
        run_block(255, 1'b0, 8, 1'b0, 70);

        // Randomized blocks.
        for (int b = 0; b < 16; b++) begin
            bit ul;
            int len;
            int dens;
            ul   = ($urandom_range(0, 3) != 0);
            len  = ul ? int'($urandom_range(1, 255)) : 255;
            dens = $urandom_range(0, 25);
            for (int i = 0; i < 255; i++) pat[i] = ($urandom_range(0, 99) < dens);
            run_block(len, ul, $urandom_range(0, 31), 1'b1, $urandom_range(40, 100));
        end

`ifdef ERASURE_PINGPONG_EN
        // Block B collected while block A is in the middle of being served.
        begin
            int nb;
            bit ob;
            clear_pat();
            pat[5] = 1'b1; pat[9] = 1'b1; pat[77] = 1'b1;
            drive_block(90, 1'b1, 16, 1'b0, n, ovf);
            check_collected(n, ovf);
            serve_step(1'b1);
            send = 1'b0;
            clear_pat();
            pat[0] = 1'b1; pat[128] = 1'b1;
            drive_block(150, 1'b1, 16, 1'b1, nb, ob);
            serve_until_done(100);
            @(negedge clock);
            check_collected(nb, ob);
            serve_until_done(80);
        end
`endif

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/erasure_position_gen.md
# erasure_position_gen

Generates the erasure root values alpha^(n-1-k) for every symbol flagged as erased in an incoming 255-symbol codeword. It buffers up to `max_erasures` roots per block. It then serves them one per cycle to the erasure locator polynomial block through the `send_erasure_positions_for_loc` / `erasure_ready` / `erase_pos_done` handshake. It sits between the symbol input/erasure-flag front end and the erasure locator polynomial generator in the RS(255,k) decoder.

## Interface
- `width`, 5, width of the erasure-count and parity-count buses.
- `max_erasures`, 16, depth of the root buffer; must be ≤ 2^width − 1.
- `block_length`, 255, number of symbols per codeword.
- `start_power`, 8'h8E, alpha^(block_length−1) in GF(2^8), primitive polynomial 0x11D (alpha^254 = 0x8E).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  a symbol slot is present this cycle.
- `in_erase`  in  1  the current symbol is erased; qualified by `in_valid`.
- `in_last`  in  1  last symbol of the block; qualified by `in_valid`.
- `no_of_parity`  in  width  2t; erasure limit for the block.
- `send_erasure_positions_for_loc`  in  1  level request from the locator for the next root.
- `erase_position`  out  8  erasure root, GF(2^8).
- `erasure_ready`  out  1  one-cycle strobe; `erase_position` is valid.
- `erase_pos_done`  out  1  level; all roots of the block have been delivered.
- `number_of_erasures`  out  width  count of stored erasures for the block being served.
- `erasure_overflow`  out  1  level; the block had more than `no_of_parity` erasures.

## Operation
- Reset values:
  - all outputs are 0.
  - FSM is in IDLE.
  - power register = `start_power`.
  - write pointer, read pointer, symbol counter and count are 0.
- FSM states: IDLE → COLLECT → READY → SEND → DONE → IDLE.
  - IDLE: the first `in_valid` moves to COLLECT; that symbol is processed as index 0.
  - COLLECT: on each `in_valid`:
    - If `in_erase` is set and `count < min(no_of_parity, max_erasures)`, store the power register in the buffer and increment count.
    - If `in_erase` is set and the limit is already reached, set `erasure_overflow` and do not store.
    - Then update the power register: p ← p·alpha^-1, i.e. `p[0] ? (p>>1)^8'h8E : p>>1`.
    - On `in_last`, or when the symbol counter reaches `block_length−1`, latch `number_of_erasures` = count and go to READY.
  - READY: the first request moves to SEND.
  - SEND: each cycle the request is high and the read pointer is below count:
    - drive the buffer entry onto `erase_position`;
    - pulse `erasure_ready`;
    - increment the read pointer.
  - When the read pointer equals count, assert `erase_pos_done` and go to DONE.
  - DONE: hold `erase_pos_done` until the next block's first `in_valid`, then clear it, reset the pointers, power register and overflow, and go to COLLECT.
- Zero erasures: in SEND, `erase_pos_done` is asserted on the first request cycle and no `erasure_ready` is pulsed.
- A request deasserted mid-SEND pauses output; the read pointer holds.
- `in_valid` in READY or SEND without ping-pong is ignored, and data is lost; the front end must stall.
- `in_erase` without `in_valid` is ignored.

## Timing
- A request sampled at edge t gives `erase_position` and `erasure_ready` registered and valid after edge t, i.e. one cycle of latency.
- N stored roots require N request cycles.
- `erase_pos_done` rises the cycle after the last `erasure_ready`; for N=0 it rises one cycle after the first request.
- `number_of_erasures` is stable from READY through DONE.
- The power register updates on the same edge the symbol is accepted.
- Reset asserted mid-operation returns the block immediately to IDLE with reset values; the partial block is discarded.

## Configuration
- `ERASURE_PINGPONG_EN` defined:
  - Two root buffers, each with its own count and overflow.
  - Collection of block m+1 proceeds into the alternate bank while block m is in READY, SEND or DONE.
  - Bank swap happens when the serving bank reaches DONE and the collecting bank has seen `in_last`.
  - If collection completes while both banks are busy, the collecting bank waits; further `in_valid` is ignored.
- Not defined: single bank, behaviour as in Operation.

## Test plan
- Erasures at indices 0, 1, 254, `no_of_parity`=16, continuous request:
  - `number_of_erasures`=3.
  - Roots 8'h8E, 8'h47, 8'h01 on three consecutive `erasure_ready` strobes.
  - `erase_pos_done` rises the following cycle.
- No erasures in the block, request asserted: no `erasure_ready`; `erase_pos_done`=1 one cycle after the request; `number_of_erasures`=0.
- 18 erasures with `no_of_parity`=16: only the first 16 are stored; `erasure_overflow`=1; exactly 16 strobes are delivered.
- Request toggled 1,0,0,1,1 with 3 stored roots: strobes occur on cycles 1, 4 and 5; no root is skipped or repeated.
- Reset pulsed during COLLECT after 5 erasures, then a new block with 2 erasures: `number_of_erasures`=2 and only the new roots are delivered.
- `ERASURE_PINGPONG_EN` defined, block B streamed during SEND of block A: A's roots and then B's roots are delivered intact and in order.
